ysyx_22040210_gshare_nslot: RTL and testbench

//  Parametrised gshare direction predictor for a FETCH_W-wide fetch bundle; successor to the fixed 2-slot gshare.

---
 rtl/ysyx_22040210_gshare_nslot_pkg.sv | 30 +++
 rtl/ysyx_22040210_gshare_nslot_pht.sv | 37 +++
 rtl/ysyx_22040210_gshare_nslot.sv | 113 +++++++++++
 tb/tb_ysyx_22040210_gshare_nslot.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040210_gshare_nslot_pkg.sv
// Shared constants and helpers for the N-slot gshare direction predictor.
// Counter encodings, default geometry, saturating update and the PHT index hash.
package ysyx_22040210_gshare_nslot_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int DEF_FETCH_W   = 2;
    localparam int DEF_BHR_W     = 8;
    localparam int DEF_PHT_IDX_W = 10;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != CTR_ST) res = ctr + 2'd1;
        if (!taken && ctr != CTR_SNT) res = ctr - 2'd1;
        return res;
    endfunction

    // Word-aligned PC bits folded with zero-extended history; caller truncates to idx_w.
    function automatic logic [31:0] pht_hash(input logic [63:0] pc, input logic [31:0] hist,
                                             input int idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc[33:2] & mask) ^ hist;
    endfunction

endpackage

// File: rtl/ysyx_22040210_gshare_nslot_pht.sv
// Pattern history table: 2-bit counters in a register array, FETCH_W async read ports,
// one synchronous write port. Same-cycle read of a written entry returns the old value.
module ysyx_22040210_gshare_nslot_pht
    import ysyx_22040210_gshare_nslot_pkg::*;
#(
    parameter int FETCH_W   = DEF_FETCH_W,
    parameter int PHT_IDX_W = DEF_PHT_IDX_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FETCH_W*PHT_IDX_W-1:0]   rd_idx,
    output logic [2*FETCH_W-1:0]           rd_ctr,
    input  logic                           wr_en,
    input  logic [PHT_IDX_W-1:0]           wr_idx,
    input  logic [1:0]                     wr_ctr
);

    localparam int PHT_SIZE = 1 << PHT_IDX_W;

    logic [1:0] pht [PHT_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CTR_WNT;
        end else if (wr_en) begin
            pht[wr_idx] <= wr_ctr;
        end
    end

    always_comb begin
        rd_ctr = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            rd_ctr[2*k +: 2] = pht[rd_idx[k*PHT_IDX_W +: PHT_IDX_W]];
        end
    end

endmodule

// File: rtl/ysyx_22040210_gshare_nslot.sv
// Parametrised gshare predictor for a FETCH_W-slot fetch bundle with in-bundle history
// chaining, speculative BHR, EX-time repair and commit-time PHT training.
module ysyx_22040210_gshare_nslot
    import ysyx_22040210_gshare_nslot_pkg::*;
#(
    parameter int FETCH_W   = DEF_FETCH_W,
    parameter int ADDR_W    = 64,
    parameter int BHR_W     = DEF_BHR_W,
    parameter int PHT_IDX_W = DEF_PHT_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   req_valid_i,
    input  logic [ADDR_W-1:0]      req_pc_i,
    input  logic [FETCH_W-1:0]     slot_br_i,
    output logic                   pred_vld_o,
    output logic [FETCH_W-1:0]     taken_o,
    output logic [2*FETCH_W-1:0]   ctr_o,
    output logic [BHR_W-1:0]       bhr_o,
    input  logic                   fix_vld_i,
    input  logic [BHR_W-1:0]       fix_bhr_i,
    input  logic                   fix_taken_i,
    input  logic                   upd_vld_i,
    input  logic [ADDR_W-1:0]      upd_pc_i,
    input  logic [BHR_W-1:0]       upd_bhr_i,
    input  logic [1:0]             upd_ctr_i,
    input  logic                   upd_taken_i
);

    // Handshake: a request is accepted when req_valid_i is high and none of rst, fix_vld_i,
    // stall, flush is; its response is presented with pred_vld_o exactly one cycle later.
    // There is no ready: a dropped request must be re-presented by fetch.

    logic [BHR_W-1:0]             bhr_q;
    logic [FETCH_W*PHT_IDX_W-1:0] rd_idx;
    logic [2*FETCH_W-1:0]         rd_ctr;
    logic [FETCH_W-1:0]           taken_d;
    logic [2*FETCH_W-1:0]         ctr_d;
    logic [BHR_W-1:0]             bhr_d;
    logic [PHT_IDX_W-1:0]         wr_idx;

    ysyx_22040210_gshare_nslot_pht #(
        .FETCH_W   (FETCH_W),
        .PHT_IDX_W (PHT_IDX_W)
    ) u_pht (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (rd_idx),
        .rd_ctr (rd_ctr),
        .wr_en  (upd_vld_i),
        .wr_idx (wr_idx),
        .wr_ctr (ctr_next(upd_ctr_i, upd_taken_i))
    );

    assign wr_idx = PHT_IDX_W'(pht_hash(64'(upd_pc_i), 32'(upd_bhr_i), PHT_IDX_W));

    // A slot only matters while every earlier branch slot is predicted not-taken, so its
    // history is the BHR with zeros shifted in; indices never depend on PHT read data.
    always_comb begin
        logic [BHR_W-1:0] h;
        h      = bhr_q;
        rd_idx = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            rd_idx[k*PHT_IDX_W +: PHT_IDX_W] =
                PHT_IDX_W'(pht_hash(64'(req_pc_i + ADDR_W'(4 * k)), 32'(h), PHT_IDX_W));
            if (slot_br_i[k]) h = h << 1;
        end
    end

    always_comb begin
        logic stop;
        stop    = 1'b0;
        taken_d = '0;
        ctr_d   = '0;
        bhr_d   = bhr_q;
        for (int k = 0; k < FETCH_W; k++) begin
            if (!stop) begin
                ctr_d[2*k +: 2] = rd_ctr[2*k +: 2];
                if (slot_br_i[k]) begin
                    taken_d[k] = rd_ctr[2*k+1];
                    bhr_d      = (bhr_d << 1) | BHR_W'(rd_ctr[2*k+1]);
                    stop       = rd_ctr[2*k+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bhr_q      <= '0;
            pred_vld_o <= 1'b0;
            taken_o    <= '0;
            ctr_o      <= '0;
            bhr_o      <= '0;
        end else if (fix_vld_i) begin
            bhr_q      <= (fix_bhr_i << 1) | BHR_W'(fix_taken_i);
            pred_vld_o <= 1'b0;
        end else if (flush) begin
            pred_vld_o <= 1'b0;
        end else if (!stall) begin
            pred_vld_o <= req_valid_i;
            if (req_valid_i) begin
                taken_o <= taken_d;
                ctr_o   <= ctr_d;
                bhr_o   <= bhr_q;
                bhr_q   <= bhr_d;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040210_gshare_nslot.sv
// Directed plus randomized bench for the N-slot gshare predictor against a behavioural model.
module tb_ysyx_22040210_gshare_nslot;

  localparam int FW = 2;
  localparam int AW = 64;
  localparam int HW = 8;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rst, stall, flush, req_valid_i;
  logic [AW-1:0] req_pc_i;
  logic [FW-1:0] slot_br_i;
  logic          pred_vld_o;
  logic [FW-1:0] taken_o;
  logic [2*FW-1:0] ctr_o;
  logic [HW-1:0] bhr_o;
  logic          fix_vld_i, fix_taken_i, upd_vld_i, upd_taken_i;
  logic [HW-1:0] fix_bhr_i, upd_bhr_i;
  logic [AW-1:0] upd_pc_i;
  logic [1:0]    upd_ctr_i;

  int vectors = 0;
  int miscompares = 0;

  int            m_pht [1 << IW];
  logic [HW-1:0] m_bhr;
  logic          exp_vld;
  logic [FW-1:0] exp_taken;
  logic [2*FW-1:0] exp_ctr;
  logic [HW-1:0] exp_bhr;

  ysyx_22040210_gshare_nslot dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .slot_br_i(slot_br_i),
    .pred_vld_o(pred_vld_o), .taken_o(taken_o), .ctr_o(ctr_o), .bhr_o(bhr_o),
    .fix_vld_i(fix_vld_i), .fix_bhr_i(fix_bhr_i), .fix_taken_i(fix_taken_i),
    .upd_vld_i(upd_vld_i), .upd_pc_i(upd_pc_i), .upd_bhr_i(upd_bhr_i),
    .upd_ctr_i(upd_ctr_i), .upd_taken_i(upd_taken_i)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [AW-1:0] pc, input logic [HW-1:0] h);
    return int'((pc >> 2) % 64'd1024) ^ int'(h);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model follows the rules literally: slot-by-slot chaining with the predicted bits.
  task automatic model_step();
    logic [HW-1:0] h;
    logic          seen;
    logic [1:0]    c;
    logic [FW-1:0] tk;
    logic [2*FW-1:0] ct;
    int            u;
    if (rst) begin
      for (int i = 0; i < (1 << IW); i++) m_pht[i] = 1;
      m_bhr = '0; exp_vld = 1'b0; exp_taken = '0; exp_ctr = '0; exp_bhr = '0;
      return;
    end
    h = m_bhr; seen = 1'b0; tk = '0; ct = '0;
    for (int k = 0; k < FW; k++) begin
      if (!seen) begin
        c = 2'(m_pht[idx_of(req_pc_i + AW'(4 * k), h)]);
        ct[2*k +: 2] = c;
        if (slot_br_i[k]) begin
          tk[k] = c[1];
          h = {h[HW-2:0], c[1]};
          seen = c[1];
        end
      end
    end
    if (fix_vld_i) begin
      m_bhr = {fix_bhr_i[HW-2:0], fix_taken_i};
      exp_vld = 1'b0;
    end else if (flush) begin
      exp_vld = 1'b0;
    end else if (!stall) begin
      exp_vld = req_valid_i;
      if (req_valid_i) begin
        exp_taken = tk; exp_ctr = ct; exp_bhr = m_bhr; m_bhr = h;
      end
    end
    if (upd_vld_i) begin
      u = idx_of(upd_pc_i, upd_bhr_i);
      if (upd_taken_i) m_pht[u] = (upd_ctr_i == 2'b11) ? 3 : int'(upd_ctr_i) + 1;
      else             m_pht[u] = (upd_ctr_i == 2'b00) ? 0 : int'(upd_ctr_i) - 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pred_vld", 64'(pred_vld_o), 64'(exp_vld));
    if (exp_vld) begin
      chk("taken", 64'(taken_o), 64'(exp_taken));
      chk("ctr", 64'(ctr_o), 64'(exp_ctr));
      chk("bhr_o", 64'(bhr_o), 64'(exp_bhr));
    end
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; req_valid_i = 1'b0;
    req_pc_i = '0; slot_br_i = '0;
    fix_vld_i = 1'b0; fix_bhr_i = '0; fix_taken_i = 1'b0;
    upd_vld_i = 1'b0; upd_pc_i = '0; upd_bhr_i = '0; upd_ctr_i = '0; upd_taken_i = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] pc, input logic [FW-1:0] br);
    req_valid_i = 1'b1; req_pc_i = pc; slot_br_i = br;
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic [HW-1:0] h,
                     input logic [1:0] c, input logic t);
    upd_vld_i = 1'b1; upd_pc_i = pc; upd_bhr_i = h; upd_ctr_i = c; upd_taken_i = t;
  endtask

  task automatic fix(input logic [HW-1:0] h, input logic t);
    fix_vld_i = 1'b1; fix_bhr_i = h; fix_taken_i = t;
  endtask

  initial begin
    logic [AW-1:0] pc_pool [8];
    idle();
    rst = 1'b1; req(64'h1000, 2'b11);
    tick(); tick();
    chk("rst_vld", 64'(pred_vld_o), 64'd0);
    chk("rst_taken", 64'(taken_o), 64'd0);
    chk("rst_ctr", 64'(ctr_o), 64'd0);
    chk("rst_bhr", 64'(bhr_o), 64'd0);

    // Cold lookup: both slots weakly not-taken.
    idle(); req(64'h1000, 2'b11); tick();
    chk("t1_vld", 64'(pred_vld_o), 64'd1);
    chk("t1_taken", 64'(taken_o), 64'b00);
    chk("t1_ctr", 64'(ctr_o), 64'b0101);
    chk("t1_bhr", 64'(bhr_o), 64'h00);

    // Train idx 0 to strongly taken, then slot 0 predicts taken and masks slot 1.
    idle(); upd(64'h1000, 8'h00, 2'b01, 1'b1); tick();
    idle(); upd(64'h1000, 8'h00, 2'b10, 1'b1); tick();
    idle(); req(64'h1000, 2'b11); tick();
    chk("t2_taken", 64'(taken_o), 64'b01);
    chk("t2_ctr", 64'(ctr_o), 64'b0011);
    chk("t2_bhr", 64'(bhr_o), 64'h00);

    // Stalled request holds outputs; repair still acts during stall.
    idle(); stall = 1'b1; req(64'h1040, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_vld", 64'(pred_vld_o), 64'd1);
      chk("t3_hold_taken", 64'(taken_o), 64'b01);
      chk("t3_hold_ctr", 64'(ctr_o), 64'b0011);
    end
    fix(8'hA5, 1'b1); tick();
    chk("t3_fix_vld", 64'(pred_vld_o), 64'd0);
    idle(); req(64'h1000, 2'b00); tick();
    chk("t3_bhr", 64'(bhr_o), 64'h4B);

    // Repair beats a same-cycle accepted request.
    idle(); req(64'h1000, 2'b11); fix(8'h0F, 1'b0); tick();
    chk("t4_vld", 64'(pred_vld_o), 64'd0);
    idle(); req(64'h1000, 2'b00); tick();
    chk("t4_bhr", 64'(bhr_o), 64'h1E);

    // Read/write collision returns the old counter; saturated value appears next read.
    idle(); req(64'h2000, 2'b01); upd(64'h2000, 8'h1E, 2'b11, 1'b1); tick();
    chk("t5_old_ctr", 64'(ctr_o), 64'b0101);
    chk("t5_old_taken", 64'(taken_o), 64'b00);
    idle(); fix(8'h0F, 1'b0); tick();
    idle(); req(64'h2000, 2'b01); tick();
    chk("t5_new_ctr", 64'(ctr_o), 64'b0011);
    chk("t5_new_taken", 64'(taken_o), 64'b01);

    // Not-taken training at 00 stays at 00.
    idle(); upd(64'h3000, 8'h00, 2'b00, 1'b0); fix(8'h00, 1'b0); tick();
    idle(); req(64'h3000, 2'b00); tick();
    chk("t6_sat_ctr", 64'(ctr_o), 64'b0100);

    // Reset while a response is outstanding.
    idle(); req(64'h1000, 2'b00); tick();
    idle(); rst = 1'b1; req(64'h1000, 2'b11); tick();
    chk("t6_rst_vld", 64'(pred_vld_o), 64'd0);
    chk("t6_rst_ctr", 64'(ctr_o), 64'd0);
    idle(); req(64'h1000, 2'b00); tick();
    chk("t6_pht_clr0", 64'(ctr_o), 64'b0101);
    idle(); req(64'h2078, 2'b00); tick();
    chk("t6_pht_clr1", 64'(ctr_o), 64'b0101);

    // Randomized traffic over a small PC pool so training and lookups meet.
    for (int i = 0; i < 8; i++) pc_pool[i] = AW'($urandom_range(0, 4095)) << 2;
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) != 0) req(pc_pool[$urandom_range(0, 7)], FW'($urandom));
      if ($urandom_range(0, 9) == 0) fix(HW'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0)
        upd(pc_pool[$urandom_range(0, 7)],
            ($urandom_range(0, 1) == 0) ? m_bhr : HW'($urandom_range(0, 3)),
            2'($urandom), 1'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
